// File: rtl/mult_accumulator_pkg.sv
// Shared constants and FSM state type for the product accumulator.
package mult_accumulator_pkg;

  localparam int PROD_W    = 8;
  localparam int N_DEFAULT = 4;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

endpackage

// File: rtl/mult_accumulator.sv
// Sums groups of N unsigned products and holds each group sum until taken downstream.
// Result valid 1 cycle after the Nth accept; input stalls (in_ready=0) while a sum is held.
module mult_accumulator #(
  parameter int N      = mult_accumulator_pkg::N_DEFAULT,
  parameter int PROD_W = mult_accumulator_pkg::PROD_W,
  parameter int ACC_W  = PROD_W + $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum
);
  import mult_accumulator_pkg::*;

  localparam int             CNT_W    = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_hs, out_hs;

  // Handshake flags are masked by rst so nothing transfers during reset.
  always_comb begin
    in_ready  = (state_q == ST_ACC) && !rst;
    out_valid = (state_q == ST_DONE) && !rst;
    out_sum   = acc_q;
    in_hs     = in_valid && in_ready;
    out_hs    = out_valid && out_ready;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = ST_ACC;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_hs) begin
            acc_d = acc_q + ACC_W'(in_product);
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = ST_DONE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_hs) begin
            state_d = ST_ACC;
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_ACC;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/mult_accumulator.md
MULT_ACCUMULATOR -- requirements
Module: mult_accumulator

Interface
REQ-001 Parameter N, default 4, meaning products per accumulation group (N >= 2, power of two).
REQ-002 Parameter PROD_W, default 8, meaning product width (fixed at 8; matches the 4x4 array multiplier output).
REQ-003 Parameter ACC_W, default PROD_W + clog2(N), meaning accumulator/result width (10 for N=4).
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 clear  input  1  synchronous abort of current group.
REQ-008 in_valid  input  1  in_product holds a valid product.
REQ-009 in_ready  output  1  block accepts a product this cycle.
REQ-010 in_product  input  PROD_W  unsigned product from the array multiplier.
REQ-011 out_valid  output  1  out_sum holds a completed group sum.
REQ-012 out_ready  input  1  downstream accepts out_sum this cycle.
REQ-013 out_sum  output  ACC_W  unsigned sum of N accepted products.

Function
REQ-014 Two-state FSM SHALL be used: ACC (collecting) and DONE (holding result).
REQ-015 In ACC: in_ready=1 and out_valid=0; in DONE: in_ready=0 and out_valid=1.
REQ-016 An input handshake SHALL occur when in_valid && in_ready at a rising edge: acc <= acc + in_product, cnt <= cnt + 1.
REQ-017 A handshake with cnt == N-1 SHALL move the FSM to DONE; out_valid rises in the next cycle with out_sum = sum of the N products.
REQ-018 Latency: out_valid rises exactly 1 cycle after the Nth input handshake.
REQ-019 Addition SHALL be unsigned, zero-extended to ACC_W; overflow is impossible by width (N*255 < 2^ACC_W).
REQ-020 cnt SHALL be clog2(N) bits, reset to 0 on group completion, and never wrap silently inside a group.
REQ-021 In DONE: out_sum and out_valid SHALL stay stable while out_ready=0, for any number of cycles.
REQ-022 in_valid SHALL be ignored in DONE; no product is lost, because in_ready=0.
REQ-023 An output handshake (out_valid && out_ready) SHALL clear acc and cnt to 0 and return to ACC; in_ready=1 in the following cycle (group throughput N+1 cycles).
REQ-024 in_valid=0 cycles in ACC SHALL leave acc and cnt unchanged; gaps are allowed anywhere in a group.
REQ-025 clear=1 SHALL force acc=0, cnt=0, state=ACC at the next edge, overriding a simultaneous input or output handshake; the product offered in that cycle is discarded.
REQ-026 clear in DONE SHALL drop the held result; out_valid=0 from the next cycle.
REQ-027 out_sum SHALL equal acc in all states; the value is only meaningful while out_valid=1.

Reset
REQ-028 rst=1 at a rising edge SHALL set state=ACC, acc=0, cnt=0, and SHALL take priority over clear and all handshakes.
REQ-029 Output reset values: in_ready=0 while rst=1, then 1 from the first cycle after deassertion; out_valid=0; out_sum=0.
REQ-030 rst asserted mid-group or in DONE SHALL discard all partial or held data with no output handshake.

Structure
REQ-031 A shared package SHALL hold PROD_W, the default N, and the two-value FSM state enum.
REQ-032 Single module, no sub-modules: accumulator register, counter and FSM inline; in_ready/out_valid decoded from state (and rst).

Verification
REQ-033 N=4, products 1,4,0,225 back-to-back, out_ready=1 -> out_valid for 1 cycle, 1 cycle after 4th accept, out_sum=230, then acc=0.
REQ-034 N=4, four products of 225 with in_valid gaps between them -> out_sum=900 (0x384); no overflow.
REQ-035 Group complete, out_ready=0 for 5 cycles with in_valid=1 -> out_sum held at its value, in_ready=0, no product absorbed; out_ready=1 -> next group starts from 0.
REQ-036 Two products (10, 20) accepted, then clear together with in_valid (product 30) -> acc=0, cnt=0; next 4 products 1,1,1,1 -> out_sum=4.
REQ-037 rst pulsed mid-group and in DONE -> out_valid=0, out_sum=0, in_ready=0 during rst and 1 after; a fresh group of 2,2,2,2 -> out_sum=8.
REQ-038 Scoreboard: random in_valid/out_ready over 1000 groups of random 4x4 products -> every out_sum equals the reference sum, no dropped or duplicated products.
